// File: rtl/cpu_trace_buffer_if.sv
// cpu_trace_buffer_if: capture-side and drain-side signals of the CPU trace buffer.
// master = the environment (CPU tap plus consumer); slave = the trace buffer itself.
interface cpu_trace_buffer_if #(
    parameter int unsigned P_DEPTH  = 16,
    parameter int unsigned P_DROP_W = 8
);
    localparam int unsigned CW = $clog2(P_DEPTH) + 1;

    logic                i_en;
    logic [31:0]         i_cpu_data;
    logic [7:0]          i_cpu_state;
    logic                i_ready;
    logic                i_clr_ovf;
    logic                o_valid;
    logic [31:0]         o_data;
    logic [CW-1:0]       o_count;
    logic                o_overflow;
    logic [P_DROP_W-1:0] o_drop_cnt;

    modport master (
        output i_en, i_cpu_data, i_cpu_state, i_ready, i_clr_ovf,
        input  o_valid, o_data, o_count, o_overflow, o_drop_cnt
    );

    modport slave (
        input  i_en, i_cpu_data, i_cpu_state, i_ready, i_clr_ovf,
        output o_valid, o_data, o_count, o_overflow, o_drop_cnt
    );
endinterface

// File: rtl/cpu_trace_buffer.sv
// cpu_trace_buffer: captures the CPU data word on entry into the result-valid state
// into a show-ahead FIFO, drained by a valid/ready consumer, with sticky overflow
// and a saturating dropped-capture counter.
// Optional feature: define CPU_TRACE_DEDUP_EN to suppress captures whose data
// equals the most recently pushed word.
// P_DEPTH must be a power of two and at least 2.
module cpu_trace_buffer #(
    parameter int unsigned P_DEPTH     = 16,
    parameter logic [7:0]  P_CAP_STATE = 8'h04,
    parameter int unsigned P_DROP_W    = 8
) (
    input logic               i_clk,
    input logic               i_rst,
    cpu_trace_buffer_if.slave bus
);
    localparam int unsigned   AW       = $clog2(P_DEPTH);
    localparam int unsigned   CW       = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(P_DEPTH);

    logic [31:0]         mem_q [P_DEPTH];
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]       count_q, count_d;
    logic                prev_match_q, prev_match_d;
    logic                overflow_q, overflow_d;
    logic [P_DROP_W-1:0] drop_cnt_q, drop_cnt_d;
    logic [P_DROP_W-1:0] drop_base;

    logic match, dup, cap, pop, full, push, drop;

`ifdef CPU_TRACE_DEDUP_EN
    logic [31:0] last_word_q, last_word_d;
    logic        last_vld_q, last_vld_d;
`endif

    // Capture qualification, push/pop/drop decisions and next-state values.
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        match        = (bus.i_cpu_state == P_CAP_STATE);
        prev_match_d = match;
        dup          = 1'b0;
`ifdef CPU_TRACE_DEDUP_EN
        dup          = last_vld_q && (bus.i_cpu_data == last_word_q);
`endif
        cap  = bus.i_en && match && !prev_match_q && !dup;
        full = (count_q == FULL_CNT);
        pop  = (count_q != '0) && bus.i_ready;
        // A pop on the same edge frees the slot the push needs.
        push = cap && (!full || pop);
        drop = cap && full && !pop;

        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end

        // Clear first, then let a drop on the same edge count on top of it.
        overflow_d = bus.i_clr_ovf ? 1'b0 : overflow_q;
        drop_base  = bus.i_clr_ovf ? '0 : drop_cnt_q;
        drop_cnt_d = drop_base;
        if (drop) begin
            overflow_d = 1'b1;
            if (drop_base != '1) begin
                drop_cnt_d = drop_base + P_DROP_W'(1);
            end
        end

`ifdef CPU_TRACE_DEDUP_EN
        last_word_d = push ? bus.i_cpu_data : last_word_q;
        last_vld_d  = push ? 1'b1 : last_vld_q;
`endif
    end

    // Control state: pointers, occupancy, entry detector and overflow accounting.
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            prev_match_q <= 1'b0;
            overflow_q   <= 1'b0;
            drop_cnt_q   <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            prev_match_q <= prev_match_d;
            overflow_q   <= overflow_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

`ifdef CPU_TRACE_DEDUP_EN
    // Most recently pushed word, used to suppress repeated captures.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            last_word_q <= '0;
            last_vld_q  <= 1'b0;
        end else begin
            last_word_q <= last_word_d;
            last_vld_q  <= last_vld_d;
        end
    end
`endif

    // FIFO storage written on accepted pushes.
    // NOTE: the array has no reset; entries are only read once count says they were written.
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.i_cpu_data;
        end
    end

    assign bus.o_valid    = (count_q != '0);
    assign bus.o_data     = mem_q[rd_ptr_q];
    assign bus.o_count    = count_q;
    assign bus.o_overflow = overflow_q;
    assign bus.o_drop_cnt = drop_cnt_q;
endmodule

// File: tb/tb_cpu_trace_buffer.sv
// tb_cpu_trace_buffer: directed and randomized stimulus with a queue-based
// reference model and a scoreboard monitor that checks every cycle at the falling edge.
// Compile with CPU_TRACE_DEDUP_EN defined to exercise the dedup feature.
module tb_cpu_trace_buffer;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned DROP_W = 8;
    localparam logic [7:0]  CAP    = 8'h04;

    logic clk = 1'b0;
    logic rst = 1'b0;

    int total = 0;
    int bad   = 0;

    cpu_trace_buffer_if #(.P_DEPTH(DEPTH), .P_DROP_W(DROP_W)) bus ();

    cpu_trace_buffer #(
        .P_DEPTH    (DEPTH),
        .P_CAP_STATE(CAP),
        .P_DROP_W   (DROP_W)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference model state: FIFO contents, scoreboard, and overflow accounting.
    logic [31:0] model_q[$];
    logic [31:0] sb_q[$];
    bit          m_prev     = 1'b0;
    bit          m_ovf      = 1'b0;
    int          m_drops    = 0;
    bit          m_last_vld = 1'b0;
    logic [31:0] m_last     = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] sat_drops(input int d);
        return (d > 255) ? 32'd255 : 32'(d);
    endfunction

    // Reference model: apply the capture / FIFO rules once per clock edge.
    always @(posedge clk or posedge rst) begin
        bit cap;
        if (rst) begin
            model_q.delete();
            sb_q.delete();
            m_prev     = 1'b0;
            m_ovf      = 1'b0;
            m_drops    = 0;
            m_last_vld = 1'b0;
            m_last     = '0;
        end else begin
            cap = bus.i_en && (bus.i_cpu_state == CAP) && !m_prev;
`ifdef CPU_TRACE_DEDUP_EN
            if (m_last_vld && bus.i_cpu_data == m_last) cap = 1'b0;
`endif
            m_prev = (bus.i_cpu_state == CAP);
            if (bus.i_ready && model_q.size() > 0) void'(model_q.pop_front());
            if (bus.i_clr_ovf) begin
                m_ovf   = 1'b0;
                m_drops = 0;
            end
            if (cap) begin
                if (model_q.size() < DEPTH) begin
                    model_q.push_back(bus.i_cpu_data);
                    sb_q.push_back(bus.i_cpu_data);
                    m_last     = bus.i_cpu_data;
                    m_last_vld = 1'b1;
                end else begin
                    m_ovf = 1'b1;
                    m_drops++;
                end
            end
        end
    end

    // Monitor: mid-cycle compare of all outputs; pops the scoreboard on each handshake.
    always @(negedge clk) begin
        check("valid", 32'(bus.o_valid), 32'(model_q.size() != 0));
        check("count", 32'(bus.o_count), 32'(model_q.size()));
        check("overflow", 32'(bus.o_overflow), 32'(m_ovf));
        check("drop_cnt", 32'(bus.o_drop_cnt), sat_drops(m_drops));
        if (bus.o_valid) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL head: got %h expected no entry at %0t", bus.o_data, $time);
            end else begin
                check("head", bus.o_data, sb_q[0]);
                if (bus.i_ready) void'(sb_q.pop_front());
            end
        end
    end

    // One clock of stimulus: inputs set just after a rising edge, held through the next.
    task automatic cyc(input logic en, input logic [31:0] data, input logic [7:0] state,
                       input logic ready, input logic clr);
        bus.i_en        = en;
        bus.i_cpu_data  = data;
        bus.i_cpu_state = state;
        bus.i_ready     = ready;
        bus.i_clr_ovf   = clr;
        @(posedge clk);
        #1;
    endtask

    // Enter the capture state for one cycle, then leave it for one cycle.
    task automatic cap_pair(input logic [31:0] data, input logic ready);
        cyc(1'b1, data, CAP, ready, 1'b0);
        cyc(1'b1, data, 8'h00, ready, 1'b0);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 32'h0, 8'h00, 1'b1, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int exp_dedup;
        bus.i_en        = 1'b0;
        bus.i_cpu_data  = '0;
        bus.i_cpu_state = 8'h00;
        bus.i_ready     = 1'b0;
        bus.i_clr_ovf   = 1'b0;
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 32'(bus.o_valid), 32'd0);
        check("rst_count", 32'(bus.o_count), 32'd0);
        rst = 1'b0;

        // Single capture: visible one cycle later, then drained.
        cyc(1'b1, 32'hDEADBEEF, CAP, 1'b0, 1'b0);
        check("single_valid", 32'(bus.o_valid), 32'd1);
        check("single_data", bus.o_data, 32'hDEADBEEF);
        check("single_count", 32'(bus.o_count), 32'd1);
        cyc(1'b1, 32'h0, 8'h00, 1'b1, 1'b0);
        check("single_drained", 32'(bus.o_valid), 32'd0);

        // Held capture state yields one entry; re-entry yields another.
        for (int i = 0; i < 5; i++) cyc(1'b1, 32'h11, CAP, 1'b0, 1'b0);
        check("held_count", 32'(bus.o_count), 32'd1);
        cyc(1'b1, 32'h11, 8'h00, 1'b0, 1'b0);
        cap_pair(32'h22, 1'b0);
        check("reentry_count", 32'(bus.o_count), 32'd2);
        check("reentry_head", bus.o_data, 32'h11);
        drain(2);

        // Fill past capacity: 16 kept, 2 dropped.
        for (int i = 1; i <= 18; i++) cap_pair(32'(i), 1'b0);
        check("fill_count", 32'(bus.o_count), 32'd16);
        check("fill_ovf", 32'(bus.o_overflow), 32'd1);
        check("fill_drops", 32'(bus.o_drop_cnt), 32'd2);
        check("fill_head", bus.o_data, 32'd1);

        // Full with push and pop on the same edge: accepted, no drop.
        cyc(1'b1, 32'hA5A5A5A5, CAP, 1'b1, 1'b0);
        check("fullpp_count", 32'(bus.o_count), 32'd16);
        check("fullpp_drops", 32'(bus.o_drop_cnt), 32'd2);
        for (int i = 0; i < 16; i++) begin
            if (bus.o_count == 1) check("fullpp_last", bus.o_data, 32'hA5A5A5A5);
            cyc(1'b1, 32'h0, 8'h00, 1'b1, 1'b0);
        end
        check("fullpp_empty", 32'(bus.o_count), 32'd0);

        // Clear, refill, then a drop on the same edge as a clear.
        cyc(1'b1, 32'h0, 8'h00, 1'b0, 1'b1);
        check("clr_ovf", 32'(bus.o_overflow), 32'd0);
        check("clr_drops", 32'(bus.o_drop_cnt), 32'd0);
        for (int i = 0; i < 16; i++) cap_pair(32'(100 + i), 1'b0);
        cap_pair(32'd200, 1'b0);
        cap_pair(32'd201, 1'b0);
        cyc(1'b1, 32'd202, CAP, 1'b0, 1'b1);
        check("clrdrop_ovf", 32'(bus.o_overflow), 32'd1);
        check("clrdrop_drops", 32'(bus.o_drop_cnt), 32'd1);
        cyc(1'b1, 32'd202, 8'h00, 1'b0, 1'b0);
        drain(11);
        check("pre_rst_count", 32'(bus.o_count), 32'd5);

        // Asynchronous reset between clock edges takes effect immediately.
        #2 rst = 1'b1;
        #1;
        check("arst_valid", 32'(bus.o_valid), 32'd0);
        check("arst_count", 32'(bus.o_count), 32'd0);
        check("arst_ovf", 32'(bus.o_overflow), 32'd0);
        check("arst_drops", 32'(bus.o_drop_cnt), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        cyc(1'b1, 32'h55, CAP, 1'b0, 1'b0);
        check("post_rst_count", 32'(bus.o_count), 32'd1);
        check("post_rst_data", bus.o_data, 32'h55);
        cyc(1'b1, 32'h0, 8'h00, 1'b1, 1'b0);

        // Repeated data word: suppressed only when dedup is built in.
`ifdef CPU_TRACE_DEDUP_EN
        exp_dedup = 2;
`else
        exp_dedup = 3;
`endif
        cap_pair(32'd7, 1'b0);
        cap_pair(32'd7, 1'b0);
        cap_pair(32'd9, 1'b0);
        check("dedup_count", 32'(bus.o_count), 32'(exp_dedup));
        drain(3);

        // Randomized traffic with phases of slow and fast draining.
        for (int i = 0; i < 3000; i++) begin
            logic        en, rdy, clr;
            logic [7:0]  st;
            logic [31:0] dat;
            int          r;
            en  = ($urandom_range(0, 9) != 0);
            r   = $urandom_range(0, 3);
            st  = (r < 2) ? CAP : (r == 2) ? 8'h00 : 8'($urandom);
            dat = 32'($urandom_range(0, 3));
            rdy = (((i / 250) % 3) == 0) ? ($urandom_range(0, 7) == 0)
                                         : ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 63) == 0);
            cyc(en, dat, st, rdy, clr);
        end

        drain(DEPTH + 2);
        check("final_empty", 32'(bus.o_count), 32'd0);
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
